// File: rtl/cfg_axilite.sv
// AXI4-Lite slave that turns host register writes into one-cycle configuration bus pulses
// and keeps a readable shadow copy of every configuration word.
module cfg_axilite #(
  parameter int unsigned CONFIG_AWIDTH  = 5,
  parameter int unsigned CONFIG_DWIDTH  = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [CONFIG_AWIDTH-1:0]      cfg_addr,
  output logic [CONFIG_DWIDTH-1:0]      cfg_data,
  output logic                          cfg_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [CONFIG_DWIDTH-1:0]      axi_wdata,
  input  logic [CONFIG_DWIDTH/8-1:0]    axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_araddr,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [CONFIG_DWIDTH-1:0]      axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready
);

  localparam int unsigned DEPTH = 1 << CONFIG_AWIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [CONFIG_DWIDTH-1:0] shadow [DEPTH];

  logic                     aw_held;
  logic                     w_held;
  logic                     w_full;
  logic [CONFIG_AWIDTH-1:0] aw_idx;
  logic [CONFIG_AWIDTH-1:0] ar_idx;
  logic [CONFIG_DWIDTH-1:0] w_data;
  logic                     issue;
  logic                     unused_addr_bits;

  // Only the word index is decoded; everything else aliases.
  assign ar_idx           = axi_araddr[CONFIG_AWIDTH+1:2];
  assign unused_addr_bits = ^{axi_awaddr, axi_araddr};

  assign axi_awready = !aw_held;
  assign axi_wready  = !w_held;
  assign axi_arready = !axi_rvalid;

  assign issue = aw_held && w_held && !axi_bvalid;

  // Write path: independent AW/W holding registers, issue once both are held and B is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      w_full     <= 1'b0;
      aw_idx     <= '0;
      w_data     <= '0;
      cfg_valid  <= 1'b0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
      for (int i = 0; i < int'(DEPTH); i++) begin
        shadow[i] <= '0;
      end
    end else begin
      cfg_valid <= 1'b0;

      if (axi_awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_idx  <= axi_awaddr[CONFIG_AWIDTH+1:2];
      end

      if (axi_wvalid && !w_held) begin
        w_held <= 1'b1;
        w_data <= axi_wdata;
        w_full <= &axi_wstrb;
      end

      if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
      end

      // Issue never coincides with a new accept: both ready flags are low while held.
      if (issue) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        axi_bvalid <= 1'b1;
        if (w_full) begin
          cfg_valid      <= 1'b1;
          cfg_addr       <= aw_idx;
          cfg_data       <= w_data;
          shadow[aw_idx] <= w_data;
          axi_bresp      <= RESP_OKAY;
        end else begin
          axi_bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read path: the shadow is sampled before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_rvalid <= 1'b0;
      axi_rresp  <= RESP_OKAY;
      axi_rdata  <= '0;
    end else begin
      if (axi_rvalid && axi_rready) begin
        axi_rvalid <= 1'b0;
      end
      if (axi_arvalid && !axi_rvalid) begin
        axi_rvalid <= 1'b1;
        axi_rresp  <= RESP_OKAY;
        axi_rdata  <= shadow[ar_idx];
      end
    end
  end

endmodule

// File: doc/cfg_axilite.md
# cfg_axilite

AXI4-Lite slave that turns host register writes into single-cycle pulses on the configuration bus (cfg_addr/cfg_data/cfg_valid). The configuration bus is broadcast to the axis write and read engines, which decode their own CONFIG_ID/ADDR/DATA words. The block keeps a shadow copy of every configuration word so the host can read back what it last wrote. It sits between the Zynq PS general-purpose AXI master port and the axis block, in the same clock domain.

## Interface
- CONFIG_AWIDTH, 5: configuration address width; 2^CONFIG_AWIDTH shadow words.
- CONFIG_DWIDTH, 32: configuration and AXI-Lite data width; fixed at 32.
- AXI_ADDR_WIDTH, 32: AXI-Lite address width; must be ≥ CONFIG_AWIDTH+2.

Ports:
- clk, in, 1: the single clock for the block.
- rst, in, 1: reset, synchronous and active-high.
- cfg_addr, out, CONFIG_AWIDTH: configuration word index.
- cfg_data, out, CONFIG_DWIDTH: configuration word value.
- cfg_valid, out, 1: one-cycle strobe; cfg_addr and cfg_data are valid while it is high.
- Write address channel:
  - axi_awaddr, in, AXI_ADDR_WIDTH
  - axi_awvalid, in, 1
  - axi_awready, out, 1
- Write data channel:
  - axi_wdata, in, CONFIG_DWIDTH
  - axi_wstrb, in, CONFIG_DWIDTH/8
  - axi_wvalid, in, 1
  - axi_wready, out, 1
- Write response channel:
  - axi_bresp, out, 2
  - axi_bvalid, out, 1
  - axi_bready, in, 1
- Read address channel:
  - axi_araddr, in, AXI_ADDR_WIDTH
  - axi_arvalid, in, 1
  - axi_arready, out, 1
- Read data channel:
  - axi_rdata, out, CONFIG_DWIDTH
  - axi_rresp, out, 2
  - axi_rvalid, out, 1
  - axi_rready, in, 1

## Operation
- Word index is addr[CONFIG_AWIDTH+1:2].
  - Bits [1:0] and all bits above CONFIG_AWIDTH+1 are ignored, so the register window aliases.
- Write path has two independent holding registers with flags aw_held and w_held.
  - axi_awready = !aw_held.
  - axi_wready = !w_held.
  - AW and W may arrive in either order, in the same cycle, or many cycles apart.
- Issue condition: aw_held && w_held && !axi_bvalid. At the clock edge where it is true:
  - Full strobe (axi_wstrb all ones):
    - cfg_valid <= 1, cfg_addr <= held index, cfg_data <= held data.
    - shadow[index] <= data.
    - axi_bresp <= 2'b00 (OKAY).
  - Partial strobe (any wstrb bit zero):
    - No cfg pulse and no shadow update.
    - axi_bresp <= 2'b10 (SLVERR).
  - In both cases: axi_bvalid <= 1 and both held flags clear.
- axi_bvalid stays high until axi_bready is sampled high, then clears.
- A new AW/W pair may be accepted while axi_bvalid is high. It does not issue until the response is retired.
- cfg_valid is high for exactly one cycle per accepted full-strobe write. cfg_addr and cfg_data hold their last value otherwise.
- Read path:
  - axi_arready = !axi_rvalid.
  - On an AR handshake: axi_rdata <= shadow[index], axi_rresp <= 2'b00, axi_rvalid <= 1.
  - axi_rvalid clears on axi_rready.
- Reads and writes are fully independent and may complete in the same cycle.
- Read/write collision: if an AR handshake and a write issue target the same index on the same edge, the read returns the pre-write value.
- The shadow is a 2^CONFIG_AWIDTH × 32 register array and may be implemented as distributed RAM with one write port and one read port.

## Timing
- Reset values (rst high at a clock edge):
  - cfg_valid = 0, cfg_addr = 0, cfg_data = 0.
  - axi_bvalid = 0, axi_bresp = 0.
  - axi_rvalid = 0, axi_rresp = 0, axi_rdata = 0.
  - aw_held = 0 and w_held = 0, so axi_awready = 1 and axi_wready = 1 in the first cycle after reset.
  - All shadow words = 0.
- Write latency, with AW and W handshaking at edge E0:
  - aw_held and w_held are set after E0.
  - At E1: cfg_valid = 1 and axi_bvalid = 1 (1 cycle after the handshake).
  - If AW and W handshake on different edges, issue is at the edge after the later one.
- Write throughput:
  - With axi_bready tied high, the best case is one write every 2 cycles.
  - Back-pressure on B stalls issue only. AW and W are each still accepted once, into their holding registers.
- Read latency: axi_rvalid rises at the edge of the AR handshake (the cycle after arvalid&&arready). Best-case throughput is one read every 2 cycles.
- Reset mid-transaction: held AW/W and any pending B or R response are discarded with no cfg pulse. The host must not rely on a response across reset.
- All outputs are registered, except axi_awready, axi_wready and axi_arready, which are single-flop-derived inverters.

## Test plan
- Reset, then write addr 0x0C, data 0x0000_0017, wstrb 0xF, AW and W together:
  - cfg_valid is high for exactly 1 cycle, with cfg_addr=3 and cfg_data=0x17.
  - bresp=OKAY.
  - A read of 0x0C then returns 0x17.
- Write with W presented 5 cycles before AW (addr 0x5C, data 0xDEADBEEF):
  - wready drops after the W handshake.
  - A single cfg pulse at index 23 occurs the edge after the AW handshake.
- Partial strobe write (wstrb 0x3) to 0x04:
  - No cfg_valid.
  - bresp=2'b10.
  - Shadow[1] remains unchanged (read returns 0).
- Hold bready low for 10 cycles after the first write, while presenting a second write to 0x60:
  - The second AW and W are accepted.
  - No second cfg pulse until the cycle after the first B handshake.
  - Alias check: 0x60 maps to index 24.
- Same-edge read and write to index 2 (shadow holds 0x1, writing 0x2):
  - rdata=0x1.
  - A subsequent read returns 0x2.
- Assert rst while aw_held=1 and rvalid=1:
  - All valids are 0 and awready/wready/arready are 1 the cycle after.
  - No cfg pulse occurs.
  - All shadow reads return 0.
